// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - load-type codes and MEM->WB state encoding shared by the writeback stage
package mips_pkg;

   localparam logic [2:0] LD_W  = 3'd0;
   localparam logic [2:0] LD_H  = 3'd1;
   localparam logic [2:0] LD_HU = 3'd2;
   localparam logic [2:0] LD_B  = 3'd3;
   localparam logic [2:0] LD_BU = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2
   } wb_state_t;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// rtl/mem_wb_stage_load_align.sv - little-endian load data select/extend with misalignment detect
module load_align
   import mips_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  ld_type,
   output logic [31:0] data,
   output logic        misaligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel   = rdata[{addr, 3'b000} +: 8];
      half_sel   = addr[1] ? rdata[31:16] : rdata[15:0];
      data       = rdata;
      misaligned = 1'b0;
      case (ld_type)
         LD_W:  misaligned = (addr != 2'b00);
         LD_H:  begin data = {{16{half_sel[15]}}, half_sel}; misaligned = addr[0]; end
         LD_HU: begin data = {16'h0000, half_sel};           misaligned = addr[0]; end
         LD_B:  data = {{24{byte_sel[7]}}, byte_sel};
         LD_BU: data = {24'h000000, byte_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM->WB stage: waits for load data, aligns it, drives the regfile write port.
// Optional WB_PERF_EN adds retire_cnt/stall_cnt counters.
module mem_wb_stage
   import mips_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] in_rd,
   input  logic          in_reg_write,
   input  logic          in_is_load,
   input  logic [2:0]    in_ld_type,
   input  logic [DW-1:0] in_alu_res,
   input  logic          flush,
   input  logic          dmem_rvalid,
   input  logic [DW-1:0] dmem_rdata,
   output logic          wb_we,
   output logic [AW-1:0] wb_addr,
   output logic [DW-1:0] wb_data,
   output logic          misalign
`ifdef WB_PERF_EN
   ,
   output logic [31:0]   retire_cnt,
   output logic [31:0]   stall_cnt
`endif
);

   wb_state_t     state, state_nx;
   logic [AW-1:0] p_rd;
   logic          p_reg_write;
   logic [2:0]    p_ld_type;
   logic [1:0]    p_addr;

   logic          accept, done, use_pend;
   logic [AW-1:0] c_rd;
   logic          c_reg_write, c_is_load, c_mis, c_write;
   logic [DW-1:0] c_data, al_data;
   logic          al_mis;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept && in_is_load && !dmem_rvalid) state_nx = S_WAIT;
         S_WAIT:  if (dmem_rvalid) state_nx = S_IDLE;
                  else if (flush)  state_nx = S_DRAIN;
         S_DRAIN: if (dmem_rvalid) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // A completion either comes straight from the MEM inputs or from the latched load.
   always_comb begin
      in_ready = (state == S_IDLE);
      accept   = in_valid && in_ready && !flush;
      use_pend = (state == S_WAIT);
      done     = (accept && (!in_is_load || dmem_rvalid)) ||
                 (use_pend && dmem_rvalid && !flush);
   end

   always_ff @(posedge clk) begin
      if (state == S_IDLE && accept) begin
         p_rd        <= in_rd;
         p_reg_write <= in_reg_write;
         p_ld_type   <= in_ld_type;
         p_addr      <= in_alu_res[1:0];
      end
   end

   load_align u_load_align (
      .rdata      (dmem_rdata),
      .addr       (use_pend ? p_addr : in_alu_res[1:0]),
      .ld_type    (use_pend ? p_ld_type : in_ld_type),
      .data       (al_data),
      .misaligned (al_mis)
   );

   always_comb begin
      c_rd        = use_pend ? p_rd : in_rd;
      c_reg_write = use_pend ? p_reg_write : in_reg_write;
      c_is_load   = use_pend || in_is_load;
      c_mis       = c_is_load && al_mis;
      c_data      = c_is_load ? al_data : in_alu_res;
      c_write     = done && !c_mis && c_reg_write && (c_rd != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_we    <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
         misalign <= 1'b0;
      end else begin
         wb_we    <= c_write;
         misalign <= done && c_mis;
         if (c_write) begin
            wb_addr <= c_rd;
            wb_data <= c_data;
         end
      end
   end

`ifdef WB_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         retire_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (done && !c_mis) retire_cnt <= retire_cnt + 32'd1;
         if (state == S_WAIT || state == S_DRAIN) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule
